rip_pseudo_dma: RTL
===================

RIP_PSEUDO_DMA -- requirements
Module: rip_pseudo_dma

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, word width; address step is DATA_WIDTH/8 bytes.
- LEN_WIDTH, 16, width of the word count and the error count.
- TIMEOUT_CYCLES, 1024, watchdog limit.
REQ-002 Reset rstn is synchronous, active-low; clock clk.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rstn  in  1  sync active-low reset.
- start  in  1  job request.
- mode  in  2  00 COPY, 01 FILL, 10 CHECK, 11 NOP.
- src_addr  in  ADDR_WIDTH  read base address.
- dst_addr  in  ADDR_WIDTH  write base address.
- len  in  LEN_WIDTH  job length in words.
- pattern  in  DATA_WIDTH  fill/check seed.
- busy  out  1  job active.
- done  out  1  one-cycle end-of-job pulse.
- err_cnt  out  LEN_WIDTH  CHECK mismatch count.
- timeout  out  1  job aborted by watchdog.
- raddr/rvalid  out  ADDR_WIDTH/1  read request.
- rready  in  1  read request accepted.
- rdata  in  DATA_WIDTH  read data.
- rdone  in  1  read data valid.
- waddr/wdata/wstrb/wvalid  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  write request.
- wready  in  1  write request accepted.
- wdone  in  1  write response.

Function
REQ-004 States SHALL be IDLE, READ, READWAIT, WRITE, WRITEWAIT, DONE; busy SHALL be 1 in every state except IDLE.
REQ-005 In IDLE, start=1 SHALL latch mode, src_addr, dst_addr, len and pattern, clear idx, err_cnt and timeout, and move to:
- READ for COPY/CHECK;
- WRITE for FILL;
- DONE for NOP or len==0.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 Word idx SHALL use read address src+idx*(DATA_WIDTH/8) and write address dst+idx*(DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH.
REQ-008 rvalid/wvalid SHALL assert on entry to READ/WRITE with address and data stable, and deassert the cycle after valid&&ready.
REQ-009 READWAIT SHALL wait for rdone and capture rdata in that cycle.
- COPY: go to WRITE with wdata=rdata.
- CHECK: compare rdata with pattern+idx (DATA_WIDTH-truncated); on mismatch, err_cnt increments, saturating at all-ones; then idx++.
REQ-010 FILL SHALL write wdata=pattern+idx (truncated).
REQ-011 wstrb SHALL be all-ones on every write.
REQ-012 WRITEWAIT SHALL wait for wdone, then idx++.
REQ-013 After each word completes, the block SHALL go to DONE if idx==len, else start the next word.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE; err_cnt and timeout SHALL hold until the next accepted start.
REQ-015 rdone/wdone arriving outside READWAIT/WRITEWAIT SHALL be ignored.
REQ-016 At most one transaction SHALL be outstanding.

Reset
REQ-017 With rstn=0 at a clock edge, the block SHALL enter IDLE with all outputs 0, including an in-flight job, which is abandoned without a done pulse.

Configuration
REQ-018 With RIP_PSEUDO_DMA_TIMEOUT_EN defined:
- a counter SHALL run while busy outside DONE and clear on each handshake, rdone or wdone;
- when it reaches TIMEOUT_CYCLES, the block SHALL drop rvalid/wvalid, set timeout=1 and go to DONE.
Without the macro, the block SHALL wait indefinitely, with timeout tied to 0.

Structure
REQ-019 The mode enum (rip_dma_mode_t) and the state enum SHALL live in package rip_const, next to B_WIDTH.
REQ-020 The watchdog SHALL be sub-module rip_watchdog, instantiated only under the macro.
REQ-021 rip_pseudo_dma SHALL NOT instantiate rip_axi_master; the integration top connects it to the rip_axi_master user ports.

Verification
REQ-022 The bench SHALL cover these scenarios:
- COPY, src=0x1000, dst=0x2000, len=4, memory model ready=1 -> reads 0x1000..0x100C, writes 0x2000..0x200C with identical data, one done pulse, err_cnt=0.
- FILL, dst=0x3000, pattern=0xA0, len=3 -> writes 0xA0,0xA1,0xA2 to 0x3000,0x3004,0x3008; no reads issued.
- CHECK, len=4, third word corrupted -> err_cnt=1 at done.
- len=0 or mode=11 -> done one cycle after start, no rvalid/wvalid; start during busy -> no effect.
- wready held low 5 cycles -> wvalid/waddr stable throughout; rstn low mid-READWAIT -> IDLE, all outputs 0, no done.
- With macro and TIMEOUT_CYCLES=16, rdone never asserted -> timeout=1 and done pulse within 17 cycles of rvalid.

Source files
------------

// File: rtl/rip_const.sv
// Shared constants for the pseudo-DMA engine: byte-lane width, job mode and FSM state enums.
// Latency: none (package only).
// Backpressure: n/a. Imported by rip_pseudo_dma.
package rip_const;

  // Bits per write-strobe lane; the address step per word is DATA_WIDTH / B_WIDTH bytes.
  localparam int B_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'b00,
    MODE_FILL  = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_NOP   = 2'b11
  } rip_dma_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_READWAIT  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITEWAIT = 3'd4,
    ST_DONE      = 3'd5
  } rip_dma_state_t;

endpackage

// File: rtl/rip_watchdog.sv
// Idle-cycle watchdog: counts cycles with no bus activity while run=1 and flags expiry.
// Latency: expired is combinational and rises during the TIMEOUT_CYCLES-th idle cycle.
// Backpressure: none; clr (any handshake/response) restarts the count.
// Ports: clk, rstn (sync, active-low), run (count enable), clr (activity seen), expired (abort request).
module rip_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of idle cycles already elapsed, so the abort fires
  // at the end of the TIMEOUT_CYCLES-th idle cycle rather than one later.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (!run || clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      expired = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rip_pseudo_dma.sv
// Pseudo-DMA job engine: COPY / FILL / CHECK / NOP over a simple one-outstanding read/write port pair.
// Latency: one word = request state + wait-for-response state; NOP or len==0 gives done the cycle after start.
// Backpressure: rvalid/wvalid hold address/data until rready/wready; waits on rdone/wdone
//   indefinitely unless RIP_PSEUDO_DMA_TIMEOUT_EN is defined, which adds an idle watchdog abort.
// Ports: start/mode/src_addr/dst_addr/len/pattern (job request, sampled in IDLE), busy/done/err_cnt/timeout
//   (status), raddr/rvalid/rready/rdata/rdone (read side), waddr/wdata/wstrb/wvalid/wready/wdone (write side).
module rip_pseudo_dma
  import rip_const::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [DATA_WIDTH-1:0]   pattern,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_WIDTH-1:0]    err_cnt,
  output logic                    timeout,
  output logic [ADDR_WIDTH-1:0]   raddr,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    rdone,
  output logic [ADDR_WIDTH-1:0]   waddr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    wdone
);

  localparam int STRB_W = DATA_WIDTH / B_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_W);

  rip_dma_state_t            state_q, state_d;
  rip_dma_mode_t             mode_q, mode_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [DATA_WIDTH-1:0]     pat_q, pat_d;
  logic [LEN_WIDTH-1:0]      idx_q, idx_d;
  logic [LEN_WIDTH-1:0]      err_q, err_d;
  logic [ADDR_WIDTH-1:0]     raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      timeout_q, timeout_d;

  logic [LEN_WIDTH-1:0]      idx_inc;
  logic                      last_word;
  logic [DATA_WIDTH-1:0]     exp_dat;
  logic                      wd_expired;

  assign idx_inc   = idx_q + LEN_WIDTH'(1);
  // idx only advances while idx < len, so comparing the incremented value is wrap-safe.
  assign last_word = (idx_inc == len_q);
  assign exp_dat   = pat_q + DATA_WIDTH'(idx_q);

`ifdef RIP_PSEUDO_DMA_TIMEOUT_EN
  logic wd_run, wd_clr;
  assign wd_run = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign wd_clr = (rvalid && rready) || (wvalid && wready) || rdone || wdone;

  rip_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .run     (wd_run),
    .clr     (wd_clr),
    .expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    pat_d     = pat_q;
    idx_d     = idx_q;
    err_d     = err_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = rip_dma_mode_t'(mode);
          len_d     = len;
          pat_d     = pattern;
          idx_d     = '0;
          err_d     = '0;
          timeout_d = 1'b0;
          raddr_d   = src_addr;
          waddr_d   = dst_addr;
          // FILL word 0 is pattern+0; COPY overwrites this with read data.
          wdata_d   = pattern;
          if (mode == MODE_NOP || len == '0) state_d = ST_DONE;
          else if (mode == MODE_FILL)        state_d = ST_WRITE;
          else                               state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (rready) state_d = ST_READWAIT;
      end

      ST_READWAIT: begin
        if (rdone) begin
          if (mode_q == MODE_CHECK) begin
            if (rdata != exp_dat && err_q != '1) err_d = err_q + LEN_WIDTH'(1);
            idx_d   = idx_inc;
            raddr_d = raddr_q + ADDR_STEP;
            waddr_d = waddr_q + ADDR_STEP;
            state_d = last_word ? ST_DONE : ST_READ;
          end else begin
            wdata_d = rdata;
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (wready) state_d = ST_WRITEWAIT;
      end

      ST_WRITEWAIT: begin
        if (wdone) begin
          idx_d   = idx_inc;
          raddr_d = raddr_q + ADDR_STEP;
          waddr_d = waddr_q + ADDR_STEP;
          if (last_word) begin
            state_d = ST_DONE;
          end else if (mode_q == MODE_FILL) begin
            wdata_d = pat_q + DATA_WIDTH'(idx_inc);
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Watchdog abort wins over any progress in the same cycle; it only fires
    // when nothing moved, so no handshake is lost.
    if (wd_expired) begin
      state_d   = ST_DONE;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      len_q     <= '0;
      pat_q     <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign rvalid  = (state_q == ST_READ);
  assign wvalid  = (state_q == ST_WRITE);
  assign raddr   = raddr_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign wstrb   = {STRB_W{wvalid}};
  assign err_cnt = err_q;
  // Never set in the default build, so this is a constant 0 there.
  assign timeout = timeout_q;

endmodule
